icache_axi_refill: RTL and testbench
====================================

ICACHE_AXI_REFILL -- requirements
Module: icache_axi_refill

Interface
REQ-001 The block SHALL have parameter ARID, default 4'h0: AXI ID driven on arid.
REQ-002 The block SHALL have port clk  input  1: sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req  input  1: refill request from the fetch stage, level, held until addr_ok.
REQ-005 The block SHALL have port addr  input  32: refill address; bits [5:0] are ignored.
REQ-006 The block SHALL have port burst  input  4: beats minus one (fetch stage drives 4'b1111).
REQ-007 The block SHALL have port addr_ok  output  1: request accepted, equal to arvalid & arready.
REQ-008 The block SHALL have port data_ok  output  1: one-cycle pulse, line valid.
REQ-009 The block SHALL have port line  output  512: assembled line; word 0 in [511:480], word 15 in [31:0].
REQ-010 The block SHALL have port refill_err  output  1: error flag, valid while data_ok=1.
REQ-011 The block SHALL have ports arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 as outputs and arready 1 as input: AXI read-address channel.
REQ-012 The block SHALL have ports rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 as inputs and rready 1 as output: AXI read-data channel.

Function
REQ-013 The FSM SHALL have states IDLE, AR, R, DONE.
REQ-014 In IDLE with req=1, at the clock edge the FSM SHALL latch araddr={addr[31:6],6'b0}, latch burst, clear line to 0, clear the beat counter, and go to AR.
REQ-015 In AR, arvalid SHALL be 1; when arready=1, the FSM SHALL go to R, and addr_ok SHALL be high in that cycle only.
REQ-016 arlen SHALL be {4'b0,latched burst}, arsize SHALL be 3'b010, arburst SHALL be 2'b01 (INCR), and arid SHALL be ARID; these SHALL be stable while arvalid=1.
REQ-017 In R, rready SHALL be 1; rready SHALL be 0 in every other state.
REQ-018 On each beat k (rvalid & rready, k counted from 0), rdata SHALL be written to line[511-32k -: 32].
REQ-019 The beat for which k equals the latched burst SHALL end the burst: the FSM SHALL go to DONE, regardless of rlast.
REQ-020 In DONE, data_ok SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-021 line SHALL hold its value from DONE until the next request is accepted in IDLE.
REQ-022 A req seen in AR, R or DONE SHALL be ignored; a req still high in the first IDLE cycle after DONE SHALL start a new refill.
REQ-023 Minimum latency with arready=1 and rvalid=1 continuous and burst=15: req accepted at edge 0, addr_ok in cycle 1, beats in cycles 2-17, data_ok in cycle 18.
REQ-024 rid SHALL not be checked.
REQ-025 A refill in progress SHALL NOT be aborted; the fetch stage discards flushed lines itself.

Reset
REQ-026 While rst=0, the block SHALL asynchronously force state=IDLE, arvalid=0, rready=0, data_ok=0, refill_err=0, line=0, beat counter=0, and araddr=0.
REQ-027 If reset is asserted mid-burst, the block SHALL drop the transfer, and after release SHALL start in IDLE with no data_ok for the dropped refill.

Configuration
REQ-028 With macro ICACHE_REFILL_ERR_EN defined, refill_err SHALL be set when any beat has rresp!=2'b00, or when rlast mismatches the terminating beat (rlast=1 before beat burst, or rlast=0 on beat burst); it SHALL be cleared at request acceptance.
REQ-029 With ICACHE_REFILL_ERR_EN undefined, refill_err SHALL be tied 0 and no checking logic SHALL exist.

Verification
REQ-030 The bench SHALL cover: req=1, addr=32'h1FC0_0044, arready=1, 16 back-to-back beats of data 32'h1000_0000+k -> araddr=32'h1FC0_0040, arlen=8'h0F, addr_ok in cycle 1, data_ok in cycle 18, line[511:480]=32'h1000_0000, line[31:0]=32'h1000_000F.
REQ-031 The bench SHALL cover: arready held 0 for 5 cycles -> arvalid and araddr stable, addr_ok=0 until arready=1, then a single addr_ok pulse.
REQ-032 The bench SHALL cover: rvalid toggled every other cycle -> exactly 16 beats captured in order, a single data_ok pulse, and line identical to the back-to-back case.
REQ-033 The bench SHALL cover: burst=4'h3, 4 beats -> arlen=8'h03, data_ok after beat 3, line[383:0]=0.
REQ-034 The bench SHALL cover: rst driven low at beat 7 -> all outputs 0 immediately, no data_ok, and the next req refills normally.
REQ-035 The bench SHALL cover, with ICACHE_REFILL_ERR_EN defined: rresp=2'b10 on beat 5 -> refill_err=1 with data_ok; the same case without the macro -> refill_err=0.

Source files
------------

// File: rtl/icache_axi_refill.sv
// AXI4 read-burst refill engine: fetches one 16-word I-cache line and assembles it MSB-first.
// Define ICACHE_REFILL_ERR_EN to enable rresp/rlast checking on refill_err.
module icache_axi_refill #(
    parameter logic [3:0] ARID = 4'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [31:0]  addr,
    input  logic [3:0]   burst,
    output logic         addr_ok,
    output logic         data_ok,
    output logic [511:0] line,
    output logic         refill_err,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t     state;
    logic [3:0] burst_q;
    logic [3:0] beat_cnt;
    logic [8:0] word_top;
    logic       beat;
    logic       accept;

    assign beat     = rvalid & rready;
    assign accept   = (state == IDLE) && req;
    assign word_top = 9'd511 - {beat_cnt, 5'd0};

    assign addr_ok = arvalid & arready;
    assign arid    = ARID;
    assign arlen   = {4'b0000, burst_q};
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // Transaction ID and the byte offset within the line carry no information here.
    logic unused_in;
    assign unused_in = ^{rid, addr[5:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            araddr   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            line     <= '0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            data_ok  <= 1'b0;
        end else begin
            // NOTE: default-then-override with <= gives a clean one-cycle pulse without a latch.
            data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        araddr   <= {addr[31:6], 6'b0};
                        burst_q  <= burst;
                        beat_cnt <= '0;
                        line     <= '0;
                        arvalid  <= 1'b1;
                        state    <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (beat) begin
                        line[word_top -: 32] <= rdata;
                        beat_cnt             <= beat_cnt + 4'd1;
                        // The latched length, not rlast, terminates the burst.
                        if (beat_cnt == burst_q) begin
                            rready  <= 1'b0;
                            data_ok <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_REFILL_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refill_err <= 1'b0;
        end else if (accept) begin
            refill_err <= 1'b0;
        end else if ((state == R) && beat &&
                     ((rresp != 2'b00) || (rlast != (beat_cnt == burst_q)))) begin
            refill_err <= 1'b1;
        end
    end
`else
    assign refill_err = 1'b0;

    logic unused_err;
    assign unused_err = ^{rresp, rlast, accept};
`endif

endmodule

// File: tb/tb_icache_axi_refill.sv
// Self-checking bench for icache_axi_refill: directed vector table, hand sequences, random refills.
module tb_icache_axi_refill;

`ifdef ICACHE_REFILL_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif
    localparam int          BUDGET = 200;
    localparam logic [3:0]  TB_ARID = 4'h5;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [31:0]  addr;
    logic [3:0]   burst;
    logic         addr_ok;
    logic         data_ok;
    logic [511:0] line;
    logic         refill_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    icache_axi_refill #(.ARID(TB_ARID)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .burst(burst),
        .addr_ok(addr_ok), .data_ok(data_ok), .line(line), .refill_err(refill_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Slave-side beat script for the next refill.
    logic [31:0] beat_data [16];
    logic [1:0]  beat_resp [16];
    logic        beat_last [16];

    // Reference model: words 0..burst in arrival order, word 0 most significant, rest zero.
    function automatic logic [511:0] model_line(input logic [3:0] b);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 16; k++)
            l = {l[479:0], (k <= int'(b)) ? beat_data[k] : 32'h0};
        return l;
    endfunction

    function automatic logic model_err(input logic [3:0] b);
        logic e;
        e = 1'b0;
        for (int k = 0; k <= int'(b); k++)
            if (beat_resp[k] != 2'b00 || beat_last[k] != (k == int'(b))) e = 1'b1;
        return ERR_ON & e;
    endfunction

    task automatic fill(input logic [31:0] base, input int mode, input int eb, input logic [3:0] b);
        for (int k = 0; k < 16; k++) begin
            beat_data[k] = base + 32'(k);
            beat_resp[k] = 2'b00;
            beat_last[k] = (k == int'(b));
        end
        if (mode == 1) beat_resp[eb] = 2'b10;
        if (mode == 2) beat_last[eb] = 1'b1;
        if (mode == 3) beat_last[b]  = 1'b0;
    endtask

    // One full refill with per-cycle protocol checks; gap 0 = rvalid always, 1 = even cycles, 2 = random.
    task automatic run_refill(input string nm, input logic [31:0] a, input logic [3:0] b,
                              input int ar_wait, input int gap,
                              output int aok_cyc, output int dok_cyc,
                              output logic [31:0] got_araddr, output logic [7:0] got_arlen,
                              output logic [511:0] got_line, output logic got_err);
        int c, nb, wcnt, done_cyc, nbeats;
        bit ar_hs, exp_arv, exp_rdy;
        logic [511:0] exp_l;
        logic exp_e;
        c = 0; nb = 0; wcnt = 0; done_cyc = 1 << 30; nbeats = int'(b) + 1;
        ar_hs = 1'b0;
        exp_l = model_line(b);
        exp_e = model_err(b);
        aok_cyc = -1; dok_cyc = -1; got_araddr = '0; got_arlen = '0; got_line = '0; got_err = 1'b0;
        req = 1'b1; addr = a; burst = b; arready = 1'b0; rvalid = 1'b0;
        while (c <= done_cyc + 2) begin
            if (c >= BUDGET) begin
                check({nm, " data_ok within budget"}, 512'(dok_cyc >= 0), 512'(1));
                break;
            end
            exp_arv = (c >= 1) && !ar_hs;
            exp_rdy = ar_hs && (nb < nbeats);
            check({nm, " arvalid"}, 512'(arvalid), 512'(exp_arv));
            check({nm, " rready"}, 512'(rready), 512'(exp_rdy));
            check({nm, " data_ok"}, 512'(data_ok), 512'(c == done_cyc));
            if (exp_arv) begin
                check({nm, " araddr"}, 512'(araddr), 512'(a & 32'hFFFF_FFC0));
                check({nm, " arlen"}, 512'(arlen), 512'({4'h0, b}));
                check({nm, " arid/arsize/arburst"}, 512'({arid, arsize, arburst}),
                      512'({TB_ARID, 3'b010, 2'b01}));
                got_araddr = araddr;
                got_arlen  = arlen;
            end
            if (c == 1) check({nm, " line cleared"}, line, '0);
            if (c == done_cyc) begin
                got_line = line;
                got_err  = refill_err;
                dok_cyc  = c;
                check({nm, " line"}, line, exp_l);
                check({nm, " refill_err"}, 512'(refill_err), 512'(exp_e));
            end
            if (c > done_cyc) check({nm, " line hold"}, line, got_line);

            arready = exp_arv && (wcnt >= ar_wait);
            if (exp_arv) wcnt++;
            rid = 4'($urandom);
            if (exp_rdy) begin
                rvalid = (gap == 0) ? 1'b1 : (gap == 1) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
                rdata  = beat_data[nb];
                rresp  = beat_resp[nb];
                rlast  = beat_last[nb];
            end else begin
                rvalid = 1'b0;
                rdata  = 32'hDEAD_BEEF;
                rresp  = 2'b00;
                rlast  = 1'b0;
            end
            #1;
            check({nm, " addr_ok"}, 512'(addr_ok), 512'(exp_arv && arready));
            if (exp_arv && arready) begin
                ar_hs   = 1'b1;
                req     = 1'b0;
                aok_cyc = c;
            end
            if (exp_rdy && rvalid) begin
                nb++;
                if (nb == nbeats) done_cyc = c + 1;
            end
            @(negedge clk);
            c++;
        end
        req = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  burst;
        int          ar_wait;
        int          gap;
        logic [31:0] base;
        int          err_mode;
        int          err_beat;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_arlen;
        int          exp_aok;
        int          exp_dok;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [31:0] a, input logic [3:0] b,
                                input int aw, input int g, input logic [31:0] base,
                                input int em, input int eb, input logic [31:0] ea,
                                input logic [7:0] el, input int ac, input int dc, input logic ee);
        vec_t v;
        v.name = n; v.addr = a; v.burst = b; v.ar_wait = aw; v.gap = g; v.base = base;
        v.err_mode = em; v.err_beat = eb; v.exp_araddr = ea; v.exp_arlen = el;
        v.exp_aok = ac; v.exp_dok = dc; v.exp_err = ee;
        return v;
    endfunction

    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin
        int aok, dok;
        logic [31:0]  ga;
        logic [7:0]   gl;
        logic [511:0] gline, line0;
        logic         gerr;
        bit           s_arv [9];
        bit           s_rdy [9];
        bit           s_dok [9];
        int           pulses;

        rst = 1'b0; req = 1'b0; addr = '0; burst = '0; arready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        line0 = '0;

        // Reset state
        #1;
        check("reset outputs", 512'({arvalid, rready, data_ok, refill_err, addr_ok}), '0);
        check("reset line", line, '0);
        check("reset araddr", 512'(araddr), '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-reset idle", 512'({arvalid, rready, data_ok}), '0);

        //            name              addr          b     aw g  base          em eb  araddr        arlen  aok dok  err
        vecs[0] = mk("b2b",           32'h1FC0_0044, 4'hF, 0, 0, 32'h1000_0000, 0, 0, 32'h1FC0_0040, 8'h0F, 1, 18, 1'b0);
        vecs[1] = mk("ar_stall",      32'h0000_0ABC, 4'hF, 5, 0, 32'h2000_0000, 0, 0, 32'h0000_0A80, 8'h0F, 6, 23, 1'b0);
        vecs[2] = mk("rvalid_toggle", 32'h1FC0_0044, 4'hF, 0, 1, 32'h1000_0000, 0, 0, 32'h1FC0_0040, 8'h0F, 1, 33, 1'b0);
        vecs[3] = mk("burst4",        32'h0000_1234, 4'h3, 0, 0, 32'h3000_0000, 0, 0, 32'h0000_1200, 8'h03, 1, 6,  1'b0);
        vecs[4] = mk("rresp_err",     32'h8000_0080, 4'hF, 0, 0, 32'h4000_0000, 1, 5, 32'h8000_0080, 8'h0F, 1, 18, ERR_ON);
        vecs[5] = mk("rlast_early",   32'hFFFF_FFFF, 4'h7, 1, 0, 32'h5000_0000, 2, 2, 32'hFFFF_FFC0, 8'h07, 2, 11, ERR_ON);
        vecs[6] = mk("rlast_missing", 32'h0000_0040, 4'h1, 0, 0, 32'h6000_0000, 3, 0, 32'h0000_0040, 8'h01, 1, 4,  ERR_ON);

        for (int i = 0; i < NV; i++) begin
            fill(vecs[i].base, vecs[i].err_mode, vecs[i].err_beat, vecs[i].burst);
            run_refill(vecs[i].name, vecs[i].addr, vecs[i].burst, vecs[i].ar_wait, vecs[i].gap,
                       aok, dok, ga, gl, gline, gerr);
            check({vecs[i].name, " tbl araddr"}, 512'(ga), 512'(vecs[i].exp_araddr));
            check({vecs[i].name, " tbl arlen"}, 512'(gl), 512'(vecs[i].exp_arlen));
            check({vecs[i].name, " tbl addr_ok cycle"}, 512'(aok), 512'(vecs[i].exp_aok));
            check({vecs[i].name, " tbl data_ok cycle"}, 512'(dok), 512'(vecs[i].exp_dok));
            check({vecs[i].name, " tbl refill_err"}, 512'(gerr), 512'(vecs[i].exp_err));
            if (i == 0) begin
                line0 = gline;
                check("b2b word0", 512'(gline[511:480]), 512'(32'h1000_0000));
                check("b2b word15", 512'(gline[31:0]), 512'(32'h1000_000F));
            end
            if (i == 2) check("toggle line equals b2b", gline, line0);
            if (i == 3) check("burst4 tail zero", 512'(gline[383:0]), '0);
        end

        // req held high through DONE: ignored there, restarts in the first IDLE cycle after.
        s_arv = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
        s_rdy = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
        s_dok = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        burst = 4'h0; arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rresp = 2'b00;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("hold c%0d arvalid", c), 512'(arvalid), 512'(s_arv[c]));
            check($sformatf("hold c%0d rready", c), 512'(rready), 512'(s_rdy[c]));
            check($sformatf("hold c%0d data_ok", c), 512'(data_ok), 512'(s_dok[c]));
            if (c == 1) check("hold araddr first", 512'(araddr), 512'(32'h0000_2000));
            if (c == 5) check("hold araddr second", 512'(araddr), 512'(32'h0000_2100));
            if (c == 3 || c == 4) check($sformatf("hold c%0d line", c), line, {32'hC000_0002, 480'h0});
            if (c == 5) check("hold c5 line cleared", line, '0);
            if (c == 7) check("hold c7 line", line, {32'hC000_0006, 480'h0});
            if (c == 3 || c == 7) check($sformatf("hold c%0d refill_err", c), 512'(refill_err), '0);
            req   = (c <= 5);
            addr  = 32'h0000_2000 + 32'(c * 64);
            rdata = 32'hC000_0000 + 32'(c);
            #1;
            check($sformatf("hold c%0d addr_ok", c), 512'(addr_ok), 512'(s_arv[c]));
            @(negedge clk);
        end
        req = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);

        // Reset asserted while beat 7 is on the bus.
        burst = 4'hF; addr = 32'h0000_3000; arready = 1'b1; rresp = 2'b00; rlast = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            req    = (c <= 1);
            rvalid = (c >= 2);
            rdata  = 32'hE000_0000 + 32'(c);
            if (c < 9) @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        check("midrst outputs", 512'({arvalid, rready, data_ok, refill_err, addr_ok}), '0);
        check("midrst line", line, '0);
        check("midrst araddr", 512'(araddr), '0);
        req = 1'b0; rvalid = 1'b0; arready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (data_ok || arvalid || rready) pulses++;
        end
        check("midrst no activity after release", 512'(pulses), '0);
        fill(32'h7000_0000, 0, 0, 4'hF);
        run_refill("after_rst", 32'h0000_4010, 4'hF, 0, 0, aok, dok, ga, gl, gline, gerr);
        check("after_rst data_ok cycle", 512'(dok), 512'(18));

        // Random refills against the model.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] ra;
            logic [3:0]  rb;
            int          kk;
            ra = $urandom;
            rb = 4'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) begin
                beat_data[k] = $urandom;
                beat_resp[k] = ($urandom_range(0, 23) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                beat_last[k] = (k == int'(rb));
            end
            if ($urandom_range(0, 5) == 0) begin
                kk = $urandom_range(0, int'(rb));
                beat_last[kk] = !beat_last[kk];
            end
            run_refill($sformatf("rand%0d", n), ra, rb, $urandom_range(0, 3), 2,
                       aok, dok, ga, gl, gline, gerr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
